cpu7_dbus_sram_bridge: RTL

Downstream neighbour of the no-cache core top. It terminates the core's cache-pipeline data bus (data_req / data_addr_ok / data_data_ok_m) and drives a simple single-outstanding SRAM-style memory port with a req/gnt command phase and an rvalid response phase. It handles cancel, prefetch, and LL/SC (LLbit kept locally), and reports bus errors back as data exceptions. It replaces a data cache in uncached builds.

---
 rtl/cpu7_dbus_sram_bridge_pkg.sv | 14 +
 rtl/cpu7_dbus_sram_bridge_llbit.sv | 46 ++++
 rtl/cpu7_dbus_sram_bridge.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/cpu7_dbus_sram_bridge_pkg.sv
// Shared constants for the uncached data-bus bridge: FSM encoding and the
// exception codes the bridge can report back to the core.
package cpu7_dbus_sram_bridge_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CMD  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  localparam logic [5:0] EXC_INT = 6'h00;
  localparam logic [5:0] EXC_ALE = 6'h09;
  localparam logic [5:0] EXC_BUS = 6'h08;

endpackage

// File: rtl/cpu7_dbus_sram_bridge_llbit.sv
// LL/SC reservation: one valid bit plus the reserved word address, with
// word-granular compares for the SC check and for snooping local stores.
module cpu7_llbit #(
  parameter int GRLEN = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             set_i,
  input  logic             clr_i,
  input  logic [GRLEN-1:0] set_addr_i,
  input  logic [GRLEN-1:0] sc_addr_i,
  input  logic [GRLEN-1:0] st_addr_i,
  output logic             sc_hit_o,
  output logic             st_hit_o
);

  logic             llbit_q, llbit_d;
  logic [GRLEN-3:0] lladdr_q, lladdr_d;
  logic             unused_lo;

  // Clear wins so a snooped store can never be masked by a same-cycle set.
  always_comb begin
    llbit_d  = llbit_q;
    lladdr_d = lladdr_q;
    if (clr_i) begin
      llbit_d = 1'b0;
    end else if (set_i) begin
      llbit_d  = 1'b1;
      lladdr_d = set_addr_i[GRLEN-1:2];
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) llbit_q <= 1'b0;
    else         llbit_q <= llbit_d;
  end

  always_ff @(posedge clk) begin
    lladdr_q <= lladdr_d;
  end

  assign sc_hit_o  = llbit_q & (lladdr_q == sc_addr_i[GRLEN-1:2]);
  assign st_hit_o  = llbit_q & (lladdr_q == st_addr_i[GRLEN-1:2]);
  assign unused_lo = ^{set_addr_i[1:0], sc_addr_i[1:0], st_addr_i[1:0]};

endmodule

// File: rtl/cpu7_dbus_sram_bridge.sv
// Uncached data-bus bridge: core cache-pipeline bus in, single-outstanding
// req/gnt + rvalid SRAM port out, with cancel, prefetch drop and LL/SC.
module cpu7_dbus_sram_bridge #(
  parameter int         GRLEN   = 32,
  parameter logic [5:0] EXC_BUS = cpu7_dbus_sram_bridge_pkg::EXC_BUS
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             data_req,
  input  logic [GRLEN-1:0] data_pc,
  input  logic             data_wr,
  input  logic [3:0]       data_wstrb,
  input  logic [GRLEN-1:0] data_addr,
  input  logic [GRLEN-1:0] data_wdata,
  input  logic             data_prefetch,
  input  logic             data_ll,
  input  logic             data_sc,
  input  logic             data_cancel,
  input  logic             data_cancel_ex2,
  input  logic             data_recv,
  output logic             data_addr_ok,
  output logic             data_data_ok_m,
  output logic [GRLEN-1:0] data_rdata_m,
  output logic             data_exception,
  output logic [5:0]       data_exccode,
  output logic [GRLEN-1:0] data_badvaddr,
  output logic             data_req_empty,
  output logic             data_scsucceed,
  output logic             mem_req,
  output logic             mem_wr,
  output logic [GRLEN-1:0] mem_addr,
  output logic [3:0]       mem_wstrb,
  output logic [GRLEN-1:0] mem_wdata,
  input  logic             mem_gnt,
  input  logic             mem_rvalid,
  input  logic [GRLEN-1:0] mem_rdata,
  input  logic             mem_err
);
  import cpu7_dbus_sram_bridge_pkg::*;

  logic [1:0]       state_q, state_d;
  logic             cancelled_q, cancelled_d;
  logic             wr_q, ll_q, sc_q, err_q, scok_q;
  logic [3:0]       wstrb_q;
  logic [GRLEN-1:0] addr_q, wdata_q, rdata_q;
  logic             cancel, accept, sc_hit, st_hit, ll_set, ll_clr;
  logic             in_cmd, in_wait, in_resp, resp_err;
  logic             unused_pc;

  assign cancel  = data_cancel | data_cancel_ex2;
  assign in_cmd  = (state_q == ST_CMD);
  assign in_wait = (state_q == ST_WAIT);
  assign in_resp = (state_q == ST_RESP);
  assign accept  = (state_q == ST_IDLE) & data_req;

  always_comb begin
    state_d     = state_q;
    cancelled_d = cancelled_q;
    case (state_q)
      ST_IDLE: begin
        // A failing SC is answered locally without touching memory.
        if (data_req && !data_prefetch) state_d = (data_sc && !sc_hit) ? ST_RESP : ST_CMD;
      end
      ST_CMD: begin
        if (mem_gnt) begin
          state_d     = ST_WAIT;
          cancelled_d = cancel;
        end else if (cancel) begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cancel) cancelled_d = 1'b1;
        if (mem_rvalid) begin
          state_d     = (cancelled_q || cancel) ? ST_IDLE : ST_RESP;
          cancelled_d = 1'b0;
        end
      end
      ST_RESP: begin
        if (cancel || data_recv) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      cancelled_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cancelled_q <= cancelled_d;
    end
  end

  // Request/response payload carries no reset; every output is gated by state.
  always_ff @(posedge clk) begin
    if (accept) begin
      wr_q    <= data_wr;
      wstrb_q <= data_wstrb;
      addr_q  <= data_addr;
      wdata_q <= data_wdata;
      ll_q    <= data_ll;
      sc_q    <= data_sc;
      rdata_q <= '0;
      err_q   <= 1'b0;
      scok_q  <= 1'b0;
    end
    if (in_wait && mem_rvalid) begin
      rdata_q <= mem_err ? '0 : mem_rdata;
      err_q   <= mem_err;
      scok_q  <= sc_q & ~mem_err;
    end
  end

  assign ll_set = in_wait & mem_rvalid & ll_q & ~mem_err & ~cancelled_q & ~cancel;
  assign ll_clr = (in_resp & data_recv & ~cancel & sc_q) | (in_cmd & mem_gnt & wr_q & st_hit);

  cpu7_llbit #(.GRLEN(GRLEN)) u_llbit (
    .clk        (clk),
    .resetn     (resetn),
    .set_i      (ll_set),
    .clr_i      (ll_clr),
    .set_addr_i (addr_q),
    .sc_addr_i  (data_addr),
    .st_addr_i  (addr_q),
    .sc_hit_o   (sc_hit),
    .st_hit_o   (st_hit)
  );

  assign resp_err       = in_resp & err_q;
  assign data_addr_ok   = accept;
  assign data_req_empty = (state_q == ST_IDLE);
  assign data_data_ok_m = in_resp;
  assign data_rdata_m   = in_resp ? rdata_q : '0;
  assign data_exception = resp_err;
  assign data_exccode   = resp_err ? EXC_BUS : 6'h00;
  assign data_badvaddr  = resp_err ? addr_q : '0;
  assign data_scsucceed = in_resp & scok_q;

  assign mem_req   = in_cmd;
  assign mem_wr    = in_cmd & wr_q;
  assign mem_addr  = in_cmd ? {addr_q[GRLEN-1:2], 2'b00} : '0;
  assign mem_wstrb = in_cmd ? (wr_q ? wstrb_q : 4'hF) : 4'h0;
  assign mem_wdata = (in_cmd & wr_q) ? wdata_q : '0;

  assign unused_pc = ^data_pc;

endmodule
